// File: rtl/riscv_seq_pkg.sv
// ============================================================================
// Module      : riscv_seq_pkg
// Description : Shared state encoding, trap causes and strobe bundle for the
//               multicycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_seq_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_EXECUTE = 3'd3;
  localparam logic [2:0] ST_MEM     = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;
  localparam logic [2:0] ST_TRAP    = 3'd6;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [1:0] CAUSE_CONFLICT = 2'd3;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic ir_load;
    logic reg_write;
    logic pc_write;
  } strobe_t;

endpackage

`default_nettype wire

// File: rtl/mem_watchdog.sv
// ============================================================================
// Module      : mem_watchdog
// Description : Counts cycles a memory request waits; flags expiry on the
//               wait cycle that reaches TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Expiry is combinational so a ready arriving that same cycle can still win.
  assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multicycle instruction sequencer with shared memory port,
//               bus watchdog, sticky trap and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer
  import riscv_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             dec_reg_write_enable,
  input  logic             dec_dmem_read_enable,
  input  logic             dec_dmem_write_enable,
  input  logic             dec_illegal,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             reg_write,
  output logic             pc_write,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  logic [2:0] next_state;
  logic [1:0] next_cause;
  strobe_t    strobes;
  logic       wd_clear;
  logic       wd_count_en;
  logic       wd_expired;

  always_comb begin
    next_state = state;
    next_cause = CAUSE_NONE;
    strobes    = '0;
    case (state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        strobes.mem_req = 1'b1;
        strobes.ir_load = mem_ready;
        if (mem_ready) begin
          next_state = ST_DECODE;
        end else if (wd_expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else if (dec_dmem_read_enable && dec_dmem_write_enable) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_CONFLICT;
        end else begin
          next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (dec_dmem_read_enable || dec_dmem_write_enable) begin
          next_state = ST_MEM;
        end else if (dec_reg_write_enable) begin
          next_state = ST_WB;
        end else begin
          strobes.pc_write = 1'b1;
          next_state       = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_MEM: begin
        strobes.mem_req      = 1'b1;
        strobes.mem_addr_sel = 1'b1;
        strobes.mem_we       = dec_dmem_write_enable;
        if (mem_ready) begin
          if (dec_dmem_read_enable) begin
            next_state = ST_WB;
          end else begin
            strobes.pc_write = 1'b1;
            next_state       = run ? ST_FETCH : ST_IDLE;
          end
        end else if (wd_expired) begin
          next_state = ST_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        strobes.reg_write = 1'b1;
        strobes.pc_write  = 1'b1;
        next_state        = run ? ST_FETCH : ST_IDLE;
      end
      ST_TRAP: begin
        next_state = ST_TRAP;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Any state change restarts the wait count, covering entry to FETCH and MEM.
  assign wd_clear    = (next_state != state);
  assign wd_count_en = strobes.mem_req && !mem_ready;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .count_en(wd_count_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      trap_cause <= CAUSE_NONE;
      retired    <= '0;
    end else begin
      state <= next_state;
      if (state != ST_TRAP && next_state == ST_TRAP) trap_cause <= next_cause;
      if (strobes.pc_write) retired <= retired + CNT_W'(1);
    end
  end

  assign mem_req      = strobes.mem_req;
  assign mem_we       = strobes.mem_we;
  assign mem_addr_sel = strobes.mem_addr_sel;
  assign ir_load      = strobes.ir_load;
  assign reg_write    = strobes.reg_write;
  assign pc_write     = strobes.pc_write;
  assign trap         = (state == ST_TRAP);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// Randomized instruction stream against a per-instruction behavioural model,
// plus directed literal pins for latency, timeout, trap, reset and wrap.
`default_nettype none

module tb_multicycle_sequencer;
  import riscv_seq_pkg::*;

  localparam int TIMEOUT = 15;
  localparam int CW      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic rw  = 1'b0;
  logic ld  = 1'b0;
  logic st  = 1'b0;
  logic ill = 1'b0;
  logic rdy = 1'b0;

  logic          mem_req, mem_we, mem_addr_sel, ir_load, reg_write, pc_write, trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] retired;
  logic [2:0]    state;

  multicycle_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (CW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .run                  (run),
    .dec_reg_write_enable (rw),
    .dec_dmem_read_enable (ld),
    .dec_dmem_write_enable(st),
    .dec_illegal          (ill),
    .mem_ready            (rdy),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr_sel         (mem_addr_sel),
    .ir_load              (ir_load),
    .reg_write            (reg_write),
    .pc_write             (pc_write),
    .trap                 (trap),
    .trap_cause           (trap_cause),
    .retired              (retired),
    .state                (state)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle
  logic [2:0]    e_state = ST_IDLE;
  logic          e_req = 0, e_we = 0, e_asel = 0, e_irl = 0, e_rw = 0, e_pcw = 0, e_trap = 0;
  logic [1:0]    e_cause = 0;
  logic [CW-1:0] e_ret = 0;
  logic          chk_en = 0;
  logic          pin_en = 0;
  logic          pin_sel = 0;
  logic [CW-1:0] pin_val = 0;

  // Model: retired count and held trap cause
  logic [CW-1:0] m_ret = 0;
  logic [1:0]    m_cause = 0;

  int tests = 0;
  int fails = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({state, mem_req, mem_we, mem_addr_sel, ir_load, reg_write, pc_write, trap, trap_cause, retired} !==
          {e_state, e_req, e_we, e_asel, e_irl, e_rw, e_pcw, e_trap, e_cause, e_ret}) begin
        fails++;
        $display("FAIL cycle t=%0t act st=%0d req=%b we=%b sel=%b irl=%b rw=%b pcw=%b trap=%b cause=%0d ret=%0d | exp st=%0d req=%b we=%b sel=%b irl=%b rw=%b pcw=%b trap=%b cause=%0d ret=%0d",
                 $time, state, mem_req, mem_we, mem_addr_sel, ir_load, reg_write, pc_write, trap, trap_cause, retired,
                 e_state, e_req, e_we, e_asel, e_irl, e_rw, e_pcw, e_trap, e_cause, e_ret);
      end
    end
    if (pin_en) begin
      tests++;
      if (pin_sel == 1'b0 && retired !== pin_val) begin
        fails++;
        $display("FAIL pin_retired t=%0t act=%0d exp=%0d", $time, retired, pin_val);
      end else if (pin_sel == 1'b1 && trap_cause !== pin_val[1:0]) begin
        fails++;
        $display("FAIL pin_cause t=%0t act=%0d exp=%0d", $time, trap_cause, pin_val[1:0]);
      end
    end
  end

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom);
  endfunction

  // One clock window: drive inputs just after the edge, publish expectations.
  task automatic cyc(input logic [2:0] st_e, input logic r, input logic [3:0] dec, input logic rn,
                     input logic req, input logic we, input logic asel, input logic irl,
                     input logic rwo, input logic pcw);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy = r;
    {rw, ld, st, ill} = dec;
    run = rn;
    e_state = st_e; e_req = req; e_we = we; e_asel = asel; e_irl = irl;
    e_rw = rwo; e_pcw = pcw; e_trap = (st_e == ST_TRAP);
    e_cause = m_cause; e_ret = m_ret;
    pin_en = 1'b0;
    chk_en = 1'b1;
    if (pcw) m_ret = m_ret + 1'b1;
  endtask

  task automatic pin(input logic sel, input logic [CW-1:0] val);
    pin_sel = sel; pin_val = val; pin_en = 1'b1;
  endtask

  // Asserted mid-cycle: outputs must clear before the next clock edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    run = rbit(); rdy = rbit(); {rw, ld, st, ill} = rnd4();
    m_ret = '0; m_cause = CAUSE_NONE;
    e_state = ST_IDLE; {e_req, e_we, e_asel, e_irl, e_rw, e_pcw, e_trap} = '0;
    e_cause = CAUSE_NONE; e_ret = '0;
    pin_en = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic go_from_idle(input int idles);
    for (int i = 0; i < idles; i++) cyc(ST_IDLE, rbit(), rnd4(), 1'b0, 0, 0, 0, 0, 0, 0);
    cyc(ST_IDLE, rbit(), rnd4(), 1'b1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic trap_phase(input int n);
    for (int i = 0; i < n; i++) cyc(ST_TRAP, rbit(), rnd4(), rbit(), 0, 0, 0, 0, 0, 0);
  endtask

  // kind: 0 ALU no-WB, 1 ALU WB, 2 load, 3 store, 4 illegal, 5 load+store
  task automatic instr(input int kind, input int fwait, input int mwait, input logic run_end,
                       output logic trapped);
    logic [3:0] d;
    logic got;
    case (kind)
      0:       d = 4'b0000;
      1:       d = 4'b1000;
      2:       d = {rbit(), 3'b100};
      3:       d = {rbit(), 3'b010};
      4:       d = {3'($urandom), 1'b1};
      default: d = {rbit(), 3'b110};
    endcase
    trapped = 1'b0;
    got = 1'b0;
    for (int i = 0; i < TIMEOUT && !got; i++) begin
      got = (i == fwait);
      cyc(ST_FETCH, got, rnd4(), rbit(), 1, 0, 0, got, 0, 0);
    end
    if (!got) begin m_cause = CAUSE_TIMEOUT; trapped = 1'b1; return; end
    cyc(ST_DECODE, rbit(), d, rbit(), 0, 0, 0, 0, 0, 0);
    if (kind == 4) begin m_cause = CAUSE_ILLEGAL; trapped = 1'b1; return; end
    if (kind == 5) begin m_cause = CAUSE_CONFLICT; trapped = 1'b1; return; end
    if (kind == 0) begin
      cyc(ST_EXECUTE, rbit(), d, run_end, 0, 0, 0, 0, 0, 1);
      return;
    end
    cyc(ST_EXECUTE, rbit(), d, rbit(), 0, 0, 0, 0, 0, 0);
    if (kind == 1) begin
      cyc(ST_WB, rbit(), rnd4(), run_end, 0, 0, 0, 0, 1, 1);
      return;
    end
    got = 1'b0;
    for (int i = 0; i < TIMEOUT && !got; i++) begin
      got = (i == mwait);
      cyc(ST_MEM, got, d, (got && kind == 3) ? run_end : rbit(),
          1, (kind == 3), 1, 0, 0, (got && kind == 3));
    end
    if (!got) begin m_cause = CAUSE_TIMEOUT; trapped = 1'b1; return; end
    if (kind == 2) cyc(ST_WB, rbit(), rnd4(), run_end, 0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    logic tr;
    logic at_idle;
    int   r, kind, fw, mw;
    logic re;

    // Reset state
    do_reset();

    // ALU op, ready in the same cycle: ir_load cycle 1, WB cycle 4
    go_from_idle(0);
    cyc(ST_FETCH,   1, 4'b1000, 1, 1, 0, 0, 1, 0, 0);
    cyc(ST_DECODE,  1, 4'b1000, 1, 0, 0, 0, 0, 0, 0);
    cyc(ST_EXECUTE, 1, 4'b1000, 1, 0, 0, 0, 0, 0, 0);
    cyc(ST_WB,      1, 4'b0000, 0, 0, 0, 0, 0, 1, 1);
    cyc(ST_IDLE,    0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    pin(1'b0, 4'd1);

    // Load with three wait cycles in MEM
    go_from_idle(1);
    instr(2, 0, 3, 1'b0, tr);
    cyc(ST_IDLE, rbit(), rnd4(), 1'b0, 0, 0, 0, 0, 0, 0);
    pin(1'b0, 4'd2);

    // Ready on the 15th waiting cycle: no trap
    go_from_idle(0);
    instr(1, TIMEOUT - 1, 0, 1'b1, tr);
    // Ready never arrives in FETCH: trap cause 2
    instr(0, TIMEOUT, 0, 1'b1, tr);
    trap_phase(3);
    pin(1'b1, 4'(CAUSE_TIMEOUT));
    do_reset();

    // Illegal opcode: sticky trap regardless of run
    go_from_idle(0);
    instr(4, 1, 0, 1'b1, tr);
    trap_phase(6);
    pin(1'b1, 4'(CAUSE_ILLEGAL));
    do_reset();

    // Reset in the middle of a store's MEM wait
    go_from_idle(0);
    cyc(ST_FETCH,   1, 4'b0010, 1, 1, 0, 0, 1, 0, 0);
    cyc(ST_DECODE,  0, 4'b0010, 1, 0, 0, 0, 0, 0, 0);
    cyc(ST_EXECUTE, 0, 4'b0010, 1, 0, 0, 0, 0, 0, 0);
    cyc(ST_MEM,     0, 4'b0010, 1, 1, 1, 1, 0, 0, 0);
    cyc(ST_MEM,     0, 4'b0010, 1, 1, 1, 1, 0, 0, 0);
    do_reset();
    cyc(ST_IDLE, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    pin(1'b0, 4'd0);

    // 16 ALU ops with a 4-bit counter wrap back to zero
    go_from_idle(0);
    for (int i = 0; i < 16; i++) instr(i % 2, 0, 0, (i != 15), tr);
    cyc(ST_IDLE, rbit(), rnd4(), 1'b0, 0, 0, 0, 0, 0, 0);
    pin(1'b0, 4'd0);

    // Randomized instruction stream
    at_idle = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (at_idle) go_from_idle($urandom_range(0, 2));
      r = $urandom_range(0, 19);
      kind = (r < 16) ? r / 4 : (r == 18) ? 4 : (r == 19) ? 5 : 2 + (r - 16);
      fw = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
      if (r == 16) fw = TIMEOUT;
      if (r == 17) mw = TIMEOUT;
      re = ($urandom_range(0, 2) != 0);
      instr(kind, fw, mw, re, tr);
      if (tr) begin
        trap_phase($urandom_range(1, 4));
        do_reset();
        at_idle = 1'b1;
      end else begin
        at_idle = !re;
      end
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    pin_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles mem_req may wait for mem_ready before a bus-error trap.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 Clocking and reset SHALL be one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 run  in  1  level enable; 1 starts/continues instruction execution.
REQ-007 dec_reg_write_enable  in  1  decoder: instruction writes the register file.
REQ-008 dec_dmem_read_enable  in  1  decoder: instruction is a load.
REQ-009 dec_dmem_write_enable  in  1  decoder: instruction is a store.
REQ-010 dec_illegal  in  1  decoder: opcode not recognised.
REQ-011 mem_ready  in  1  shared memory port completes the current request this cycle.
REQ-012 mem_req  out  1  memory request, held until mem_ready.
REQ-013 mem_we  out  1  1 = write request.
REQ-014 mem_addr_sel  out  1  0 = PC address, 1 = ALU result address.
REQ-015 ir_load  out  1  latch the fetched word into the instruction register.
REQ-016 reg_write  out  1  register-file write strobe.
REQ-017 pc_write  out  1  PC update strobe.
REQ-018 trap  out  1  sticky fault flag.
REQ-019 trap_cause  out  2  0 none, 1 illegal, 2 bus timeout, 3 load+store conflict.
REQ-020 retired  out  CNT_W  count of completed instructions.
REQ-021 state  out  3  current state encoding (debug).

Function
REQ-022 States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
REQ-023 IDLE: all strobes 0; run=1 -> FETCH next cycle.
REQ-024 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0; ir_load = mem_ready (same cycle); on mem_ready -> DECODE.
REQ-025 DECODE: dec_illegal -> TRAP (cause 1); load and store both 1 -> TRAP (cause 3); else -> EXECUTE.
REQ-026 EXECUTE: load or store -> MEM; else reg_write_enable -> WB; else pc_write=1, retire, -> FETCH if run=1, IDLE if run=0.
REQ-027 MEM: mem_req=1, mem_addr_sel=1, mem_we=dec_dmem_write_enable; on mem_ready: load -> WB; store -> pc_write=1, retire, -> FETCH/IDLE per run.
REQ-028 WB: reg_write=1, pc_write=1, retire, -> FETCH/IDLE per run; single cycle.
REQ-029 Minimum latency: ALU op with ready-in-same-cycle = 4 cycles (FETCH, DECODE, EXECUTE, WB); load = 5.
REQ-030 Decoder inputs SHALL be sampled only in DECODE/EXECUTE/MEM; values in other states are ignored.
REQ-031 run deasserted mid-instruction: current instruction completes, then IDLE; never aborts a pending mem_req.
REQ-032 Watchdog: counter clears on entry to FETCH or MEM, increments each cycle mem_req=1 and mem_ready=0; reaching TIMEOUT_CYCLES -> TRAP (cause 2), mem_req drops next cycle.
REQ-033 mem_ready in the same cycle the watchdog reaches TIMEOUT_CYCLES: ready wins, no trap.
REQ-034 TRAP: trap=1, all strobes 0, trap_cause held; exit only by rst.
REQ-035 retired increments by 1 exactly on each pc_write cycle; wraps 2^CNT_W-1 -> 0.
REQ-036 pc_write and ir_load are never asserted in the same cycle; reg_write only in WB.

Reset
REQ-037 rst=1 SHALL force immediately, without clock: state IDLE, all strobes 0, trap=0, trap_cause=0, retired=0, watchdog=0.
REQ-038 Reset mid-handshake drops mem_req asynchronously; no retire or write strobe occurs for the interrupted instruction.
REQ-039 After rst deasserts, first FETCH occurs one cycle after run is sampled 1.

Structure
REQ-040 Shared package riscv_seq_pkg SHALL hold the state encoding and trap_cause constants.
REQ-041 Watchdog SHALL be a sub-module mem_watchdog (clear, count-enable, expired output).

Verification
REQ-042 ALU op, mem_ready held 1, run=1 -> ir_load in cycle 1, reg_write+pc_write in cycle 4, retired=1.
REQ-043 Load with mem_ready delayed 3 cycles in MEM -> mem_addr_sel=1 for 4 cycles, then WB, retired=1.
REQ-044 mem_ready never asserted in FETCH, TIMEOUT_CYCLES=15 -> trap=1, trap_cause=2 after 15 waiting cycles; mem_ready arriving on cycle 15 instead -> no trap.
REQ-045 dec_illegal=1 in DECODE -> trap_cause=1, strobes 0 thereafter, run toggling has no effect until rst.
REQ-046 rst pulsed mid-MEM of a store -> mem_req 0 and state IDLE without clock edge, retired unchanged from 0 reset value.
REQ-047 CNT_W=4, 16 ALU ops -> retired wraps 15 -> 0.
